// File: rtl/quidditch_pkg.sv
// quidditch_pkg: shared button count, button indices and repeat FSM states
package quidditch_pkg;
    localparam int NUM_BUTTONS = 8;
    localparam int TEAM1_VU = 0;
    localparam int TEAM1_VD = 1;
    localparam int TEAM2_VU = 2;
    localparam int TEAM2_VD = 3;
    localparam int TEAM1_HL = 4;
    localparam int TEAM1_HR = 5;
    localparam int TEAM2_HL = 6;
    localparam int TEAM2_HR = 7;
    typedef enum logic {IDLE, HELD} rpt_state_t;
endpackage

// File: rtl/button_conditioner_if.sv
// button_conditioner_if: raw player inputs and conditioned button outputs
interface button_conditioner_if #(parameter int NUM_BUTTONS = quidditch_pkg::NUM_BUTTONS);
    logic                   game_on_switch;
    logic [NUM_BUTTONS-1:0] btn_raw;
    logic [NUM_BUTTONS-1:0] btn_level;
    logic [NUM_BUTTONS-1:0] btn_press;
    logic [NUM_BUTTONS-1:0] btn_move;
    logic                   game_on;
    modport master (output game_on_switch, btn_raw, input btn_level, btn_press, btn_move, game_on);
    modport slave  (input game_on_switch, btn_raw, output btn_level, btn_press, btn_move, game_on);
endinterface

// File: rtl/debounce_cell.sv
// debounce_cell: 2-flop synchronizer, stable-count debouncer and rise pulse
module debounce_cell #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          done;
    assign done = (sync[1] != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            cnt   <= (sync[1] == level || done) ? '0 : cnt + 1'b1;
            level <= level ^ done;
            rise  <= done & ~level;
        end
    end
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: debounced levels, press pulses and gated movement strobes.
// Define BUTTON_CONDITIONER_REPEAT_EN to add auto-repeat of held buttons.
module button_conditioner #(
    parameter int NUM_BUTTONS     = quidditch_pkg::NUM_BUTTONS,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_CYCLES   = 200000
) (
    input logic                 clk,
    input logic                 reset,
    button_conditioner_if.slave bus
);
    import quidditch_pkg::*;
    localparam int RW = REPEAT_CYCLES > 1 ? $clog2(REPEAT_CYCLES) : 1;
    logic [NUM_BUTTONS-1:0] level, press, move;
    logic                   on_level, game_on_rise_unused;
    if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
        $error("DEBOUNCE_CYCLES and REPEAT_CYCLES must be at least 1");
    end
    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_game (
        .clk(clk), .reset(reset), .raw(bus.game_on_switch), .level(on_level), .rise(game_on_rise_unused)
    );
    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_btn
        logic step;
        debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk(clk), .reset(reset), .raw(bus.btn_raw[g]), .level(level[g]), .rise(press[g])
        );
`ifdef BUTTON_CONDITIONER_REPEAT_EN
        rpt_state_t    state, state_nx;
        logic [RW-1:0] rcnt, rcnt_nx;
        logic          wrap;
        always_ff @(posedge clk) begin
            if (reset) begin
                state <= IDLE;
                rcnt  <= '0;
            end else begin
                state <= state_nx;
                rcnt  <= rcnt_nx;
            end
        end
        always_comb begin
            wrap     = (state == HELD) && level[g] && (rcnt == RW'(REPEAT_CYCLES - 1));
            rcnt_nx  = (state == HELD && !wrap) ? rcnt + 1'b1 : '0;
            state_nx = (state == IDLE) ? (press[g] ? HELD : IDLE) : (level[g] ? HELD : IDLE);
        end
        assign step = press[g] | wrap;
`else
        assign step = press[g];
`endif
        // opposing directions held together cancel each other's strobes
        assign move[g] = step & on_level & ~(level[g] & level[g ^ 1]);
    end
    assign bus.btn_level = level;
    assign bus.btn_press = press;
    assign bus.btn_move  = move;
    assign bus.game_on   = on_level;
endmodule
